// File: rtl/conv_via_tiling_sdiv_65s_34ns_32_seq_if.sv
// ----------------------------------------------------------------------------
// conv_via_tiling_sdiv_65s_34ns_32_seq_if
//   Operand/result bundle for the sequential requantisation divider.
//   master : drives ce, start, din0 (signed dividend), din1 (unsigned divisor)
//   slave  : drives busy, done (one-cycle pulse), dout (signed quotient),
//            rem (signed remainder), ovf (quotient overflow), dbz (divide by zero)
// ----------------------------------------------------------------------------
interface conv_via_tiling_sdiv_65s_34ns_32_seq_if #(
  parameter int din0_WIDTH = 65,
  parameter int din1_WIDTH = 34,
  parameter int dout_WIDTH = 32
);
  logic                         ce;
  logic                         start;
  logic signed [din0_WIDTH-1:0] din0;
  logic        [din1_WIDTH-1:0] din1;
  logic                         busy;
  logic                         done;
  logic signed [dout_WIDTH-1:0] dout;
  logic signed [din1_WIDTH:0]   rem;
  logic                         ovf;
  logic                         dbz;

  modport master (
    output ce, start, din0, din1,
    input  busy, done, dout, rem, ovf, dbz
  );

  modport slave (
    input  ce, start, din0, din1,
    output busy, done, dout, rem, ovf, dbz
  );
endinterface

// File: rtl/conv_via_tiling_sdiv_65s_34ns_32_seq.sv
// ----------------------------------------------------------------------------
// conv_via_tiling_sdiv_65s_34ns_32_seq
//   Sequential radix-2 restoring divider: signed din0_WIDTH-bit dividend by
//   unsigned din1_WIDTH-bit divisor, C semantics (quotient truncated toward
//   zero, remainder takes the dividend's sign). One quotient bit per enabled
//   cycle. Sits in the conv_via_tiling requantisation path.
// Ports
//   ap_clk  : clock, all state on rising edge
//   ap_rst  : synchronous active-high reset, aborts any operation
//   bus     : slave side of the operand/result interface
//             (ce, start, din0, din1 in; busy, done, dout, rem, ovf, dbz out)
// Timing (ce held high): operands accepted on edge N, done visible in cycle
//   N+din0_WIDTH+2; divide by zero reports two enabled cycles after start.
// ----------------------------------------------------------------------------
module conv_via_tiling_sdiv_65s_34ns_32_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 65,
  parameter int din1_WIDTH = 34,
  parameter int dout_WIDTH = 32
) (
  input  logic ap_clk,
  input  logic ap_rst,
  conv_via_tiling_sdiv_65s_34ns_32_seq_if.slave bus
);

  // ID is an instance tag only; folding it in with a zero weight keeps it
  // referenced without changing any width.
  localparam int CntW = $clog2(din0_WIDTH + 1) + 0 * ID;
  localparam int RW   = din1_WIDTH + 1;  // partial remainder width
  localparam int QW   = din0_WIDTH + 1;  // signed quotient width before truncation

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  // Magnitude of the dividend as an unsigned value; the most negative input
  // maps to 2^(din0_WIDTH-1), which still fits the unsigned width.
  function automatic logic [din0_WIDTH-1:0] abs_dividend(
    input logic signed [din0_WIDTH-1:0] x
  );
    logic [din0_WIDTH-1:0] u;
    u = x;
    return u[din0_WIDTH-1] ? (~u + din0_WIDTH'(1)) : u;
  endfunction

  function automatic logic [QW-1:0] signed_quot(
    input logic [din0_WIDTH-1:0] mag,
    input logic                  neg
  );
    logic [QW-1:0] ext;
    ext = {1'b0, mag};
    return neg ? (~ext + QW'(1)) : ext;
  endfunction

  function automatic logic [RW-1:0] signed_rem(
    input logic [RW-1:0] mag,
    input logic          neg
  );
    return neg ? (~mag + RW'(1)) : mag;
  endfunction

  // Representable in dout_WIDTH signed iff every bit from the MSB down to the
  // output sign bit is identical.
  function automatic logic quot_ovf(input logic [QW-1:0] qs);
    logic [QW-dout_WIDTH:0] top;
    top = qs[QW-1:dout_WIDTH-1];
    return (top != '0) && (top != '1);
  endfunction

  state_t                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic [din0_WIDTH-1:0]   dvd_q;   // dividend bits shift out, quotient bits shift in
  logic [din1_WIDTH-1:0]   div_q;
  logic [RW-1:0]           prem_q;
  logic                    neg_q;
  logic                    busy_q;
  logic                    done_q;
  logic [dout_WIDTH-1:0]   dout_q;
  logic [RW-1:0]           rem_q;
  logic                    ovf_q;
  logic                    dbz_q;

  logic [RW-1:0]           shl_d;
  logic [RW:0]             trial_d;
  logic                    qbit_d;
  logic [RW-1:0]           prem_d;
  logic [din0_WIDTH-1:0]   dvd_d;
  logic [QW-1:0]           qs_d;
  logic [RW-1:0]           remf_d;

  // One restoring step: bring down the next dividend bit, trial-subtract.
  // The partial remainder is always below the divisor, so its top bit is
  // zero and the shifted value still fits RW bits.
  always_comb begin
    shl_d   = {prem_q[RW-2:0], dvd_q[din0_WIDTH-1]};
    trial_d = {1'b0, shl_d} - {2'b00, div_q};
    qbit_d  = ~trial_d[RW];
    prem_d  = qbit_d ? trial_d[RW-1:0] : shl_d;
    dvd_d   = {dvd_q[din0_WIDTH-2:0], qbit_d};
    qs_d    = signed_quot(dvd_q, neg_q);
    remf_d  = signed_rem(prem_q, neg_q);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      div_q   <= '0;
      prem_q  <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else if (bus.ce) begin
      case (state_q)
        S_IDLE: begin
          // busy is still high during the done cycle, so a start there is
          // ignored and busy drops on this edge.
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start && !busy_q) begin
            dvd_q   <= abs_dividend(bus.din0);
            neg_q   <= bus.din0[din0_WIDTH-1];
            div_q   <= bus.din1;
            prem_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= (bus.din1 == '0) ? S_FINISH : S_CALC;
          end
        end
        S_CALC: begin
          prem_q <= prem_d;
          dvd_q  <= dvd_d;
          cnt_q  <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(din0_WIDTH - 1)) begin
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
          if (div_q == '0) begin
            dout_q <= '0;
            rem_q  <= '0;
            ovf_q  <= 1'b0;
            dbz_q  <= 1'b1;
          end else begin
            dout_q <= qs_d[dout_WIDTH-1:0];
            rem_q  <= remf_d;
            ovf_q  <= quot_ovf(qs_d);
            dbz_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dout = dout_q;
  assign bus.rem  = rem_q;
  assign bus.ovf  = ovf_q;
  assign bus.dbz  = dbz_q;

endmodule

// File: tb/tb_conv_via_tiling_sdiv_65s_34ns_32_seq.sv
// ----------------------------------------------------------------------------
// tb_conv_via_tiling_sdiv_65s_34ns_32_seq
//   Directed and randomized checks of the sequential divider against a
//   reference computed with wide signed '/' and '%'.
// ----------------------------------------------------------------------------
module tb_conv_via_tiling_sdiv_65s_34ns_32_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_via_tiling_sdiv_65s_34ns_32_seq_if #(
    .din0_WIDTH(65), .din1_WIDTH(34), .dout_WIDTH(32)
  ) bus ();

  conv_via_tiling_sdiv_65s_34ns_32_seq #(
    .ID(1), .din0_WIDTH(65), .din1_WIDTH(34), .dout_WIDTH(32)
  ) dut (
    .ap_clk(clk),
    .ap_rst(rst),
    .bus   (bus.slave)
  );

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: C-style truncating division on wide signed integers.
  task automatic model(input logic signed [64:0] a, input logic [33:0] b,
                       output logic [31:0] q32, output logic [34:0] r35,
                       output logic ovf, output logic dbz);
    logic signed [127:0] num, den, q, r;
    if (b == 34'd0) begin
      q32 = '0; r35 = '0; ovf = 1'b0; dbz = 1'b1;
    end else begin
      num = a;
      den = $signed({94'd0, b});
      q   = num / den;
      r   = num % den;
      q32 = q[31:0];
      r35 = r[34:0];
      ovf = (q > 128'sd2147483647) || (q < -128'sd2147483648);
      dbz = 1'b0;
    end
  endtask

  // Issue one start and step until done (bounded). Optionally: ce gap, extra
  // starts at cycles 5/20, reset pulse at a given cycle.
  task automatic run_op(input logic signed [64:0] a, input logic [33:0] b,
                        input int gap_at, input int gap_len, input bit extra,
                        input int rst_at,
                        output int lat, output bit seen, output logic busy1);
    @(negedge clk);
    bus.ce = 1'b1; bus.din0 = a; bus.din1 = b; bus.start = 1'b1;
    lat = 0; seen = 1'b0; busy1 = 1'b0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 1) busy1 = bus.busy;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (rst_at != 0 && lat > rst_at + 80) break;
      @(negedge clk);
      bus.start = extra && (lat + 1 == 5 || lat + 1 == 20);
      if (lat == 1) begin
        bus.din0 = 65'($signed({$urandom, $urandom}));
        bus.din1 = 34'($urandom);
      end
      bus.ce = !(gap_len > 0 && lat + 1 >= gap_at && lat + 1 < gap_at + gap_len);
      rst = (rst_at != 0 && lat + 1 == rst_at);
    end
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic signed [64:0] a,
                          input logic [33:0] b, input int gap_at, input int gap_len,
                          input bit extra, input bit freeze);
    logic [31:0] e_q; logic [34:0] e_r; logic e_ovf, e_dbz;
    int lat; bit seen; logic busy1;
    model(a, b, e_q, e_r, e_ovf, e_dbz);
    run_op(a, b, gap_at, gap_len, extra, 0, lat, seen, busy1);
    chk({tag, ".done_seen"}, 128'(seen), 128'(1));
    chk({tag, ".latency"}, 128'(lat), 128'(((b == 34'd0) ? 2 : 67) + gap_len));
    chk({tag, ".busy"}, 128'(busy1), 128'(1));
    chk({tag, ".dout"}, 128'(bus.dout[31:0]), 128'(e_q));
    chk({tag, ".rem"}, 128'(bus.rem[34:0]), 128'(e_r));
    chk({tag, ".ovf"}, 128'(bus.ovf), 128'(e_ovf));
    chk({tag, ".dbz"}, 128'(bus.dbz), 128'(e_dbz));
    // run_op returned at the negedge inside the done cycle
    if (freeze) begin
      bus.ce = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk({tag, ".done_frozen"}, 128'(bus.done), 128'(1));
      chk({tag, ".dout_frozen"}, 128'(bus.dout[31:0]), 128'(e_q));
      @(negedge clk);
      bus.ce = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, 128'(bus.done), 128'(0));
    chk({tag, ".busy_after"}, 128'(bus.busy), 128'(0));
    chk({tag, ".rem_hold"}, 128'(bus.rem[34:0]), 128'(e_r));
  endtask

  initial begin
    logic signed [64:0] a;
    logic [64:0] t;
    logic [33:0] b;
    int lat; bit seen; logic busy1;

    rst = 1'b1;
    bus.ce = 1'b0; bus.start = 1'b0; bus.din0 = '0; bus.din1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", 128'(bus.busy), 128'(0));
    chk("reset.done", 128'(bus.done), 128'(0));
    chk("reset.dout", 128'(bus.dout[31:0]), 128'(0));
    chk("reset.rem",  128'(bus.rem[34:0]), 128'(0));
    chk("reset.ovf",  128'(bus.ovf), 128'(0));
    chk("reset.dbz",  128'(bus.dbz), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    op_check("pos100_7", 65'sd100, 34'd7, 0, 0, 1'b0, 1'b0);
    op_check("neg100_7", -65'sd100, 34'd7, 0, 0, 1'b0, 1'b0);
    op_check("dbz", 65'sd12345, 34'd0, 0, 0, 1'b0, 1'b0);
    op_check("ovf_2p40", 65'sd1 <<< 40, 34'd1, 0, 0, 1'b0, 1'b0);
    a = {1'b1, 64'd0};
    op_check("min_div_2p33", a, 34'h2_0000_0000, 0, 0, 1'b0, 1'b0);
    op_check("zero_dividend", 65'sd0, 34'd5, 0, 0, 1'b0, 1'b0);
    a = {1'b0, {64{1'b1}}};
    op_check("max_div_max", a, {34{1'b1}}, 0, 0, 1'b0, 1'b0);
    op_check("neg_small", -65'sd3, 34'd7, 0, 0, 1'b0, 1'b0);
    op_check("neg_edge", -65'sd2147483648, 34'd1, 0, 0, 1'b0, 1'b0);
    op_check("pos_edge", 65'sd2147483648, 34'd1, 0, 0, 1'b0, 1'b0);

    // Extra starts ignored, ce gap mid-CALC stretches latency by the gap
    op_check("gap_extra", -65'sd123456789012, 34'd1000, 30, 10, 1'b1, 1'b0);

    // done held while ce is low on the done cycle
    op_check("freeze_done", 65'sd987654321, 34'd13, 0, 0, 1'b0, 1'b1);

    // Reset mid-operation aborts with no done and cleared outputs
    run_op(65'sd100, 34'd7, 0, 0, 1'b0, 30, lat, seen, busy1);
    #1;
    chk("rst_abort.no_done", 128'(seen), 128'(0));
    chk("rst_abort.busy", 128'(bus.busy), 128'(0));
    chk("rst_abort.dout", 128'(bus.dout[31:0]), 128'(0));
    chk("rst_abort.rem", 128'(bus.rem[34:0]), 128'(0));
    chk("rst_abort.dbz", 128'(bus.dbz), 128'(0));
    op_check("after_rst", -65'sd100, 34'd7, 0, 0, 1'b0, 1'b0);

    // Randomized operands over a spread of magnitudes
    for (int i = 0; i < 12; i++) begin
      t = {1'($urandom_range(1, 0)), 32'($urandom), 32'($urandom)};
      a = $signed(t) >>> $urandom_range(0, 60);
      b = 34'({2'($urandom_range(3, 0)), 32'($urandom)}) >> $urandom_range(0, 33);
      op_check($sformatf("rand%0d", i), a, b, 0, 0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
